npu_hazard_ctrl: RTL and testbench

- Parametrised pipeline hazard and flush controller for the in-order NPU Fetch/Decode/Execute/Memory/WriteBack pipeline.
- Keeps a per-register pending-write scoreboard for the scalar and vector register files and stalls Decode on RAW and WAW hazards.
- Turns branch-taken (resolved in Execute) and jump (resolved in Decode) into flush and bubble controls for the pipeline registers.
- Exports per-stage valid bits and saturating stall/flush performance counters.

---
 rtl/npu_hazard_ctrl_pkg.sv | 35 +++
 rtl/npu_scoreboard.sv | 87 ++++++++
 rtl/npu_hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_npu_hazard_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/npu_hazard_ctrl_pkg.sv
// npu_hazard_ctrl_pkg
// Shared constants and types for the NPU pipeline hazard/flush controller.
// Contents:
//   NPU_REG_AW     default register address width
//   FILE_S/FILE_V  register file indices (scalar, vector)
//   NUM_STAGES     pipeline depth (F, D, E, M, W)
//   flush_cause_e  encoding of why Decode does not advance normally
//   file_w()       width of a register-file index for a given file count
package npu_hazard_ctrl_pkg;

  localparam int NPU_REG_AW = 5;
  localparam int FILE_S     = 0;
  localparam int FILE_V     = 1;
  localparam int NUM_STAGES = 5;

  // Ordered by how the controller resolves them: a taken branch beats
  // everything, a Decode hazard beats a jump (the jump waits), and a
  // hazard-free jump only flushes Fetch.
  typedef enum logic [1:0] {
    FC_NONE   = 2'd0,
    FC_HAZ    = 2'd1,
    FC_JMP    = 2'd2,
    FC_BRANCH = 2'd3
  } flush_cause_e;

  // A single file still needs a one-bit index so port widths stay legal.
  function automatic int file_w(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/npu_scoreboard.sv
// npu_scoreboard
// Pending-write scoreboard: one bit per register across all register files,
// stored flat as {file, reg}.
// Ports:
//   clk, reset            clock, synchronous active-high reset (clears all bits)
//   clr, clr_addr         per-file writeback clear strobe and address
//   set, set_file/addr    mark a destination as pending (set wins over clear)
//   rd_*_file/addr        read ports A, B and D
//   rd_a, rd_b, rd_d      pending state seen by Decode (bypassed if WB_BYPASS)
//   bits                  raw scoreboard contents
module npu_scoreboard
  import npu_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW    = NPU_REG_AW,
  parameter int NUM_FILES = 2,
  parameter int WB_BYPASS = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_FILES-1:0]                clr,
  input  logic [NUM_FILES*REG_AW-1:0]         clr_addr,
  input  logic                                set,
  input  logic [file_w(NUM_FILES)-1:0]        set_file,
  input  logic [REG_AW-1:0]                   set_addr,
  input  logic [file_w(NUM_FILES)-1:0]        rd_a_file,
  input  logic [REG_AW-1:0]                   rd_a_addr,
  input  logic [file_w(NUM_FILES)-1:0]        rd_b_file,
  input  logic [REG_AW-1:0]                   rd_b_addr,
  input  logic [file_w(NUM_FILES)-1:0]        rd_d_file,
  input  logic [REG_AW-1:0]                   rd_d_addr,
  output logic                                rd_a,
  output logic                                rd_b,
  output logic                                rd_d,
  output logic [NUM_FILES*(2**REG_AW)-1:0]    bits
);

  localparam int NREG  = 2**REG_AW;
  localparam int NBITS = NUM_FILES * NREG;
  localparam logic [NBITS-1:0] ONE = {{(NBITS-1){1'b0}}, 1'b1};

  logic [NBITS-1:0] clr_mask;
  logic [NBITS-1:0] set_mask;
  logic [NBITS-1:0] visible;

  // One-hot mask for register r of file f; a file index beyond NUM_FILES
  // selects nothing.
  function automatic logic [NBITS-1:0] onehot(input int f, input int r);
    if ((f >= 0) && (f < NUM_FILES)) begin
      return ONE << (f * NREG + r);
    end else begin
      return {NBITS{1'b0}};
    end
  endfunction

  // Collect this cycle's writeback clears from every file.
  always_comb begin
    clr_mask = {NBITS{1'b0}};
    for (int f = 0; f < NUM_FILES; f++) begin
      clr_mask = clr_mask |
                 (clr[f] ? onehot(f, int'(clr_addr[f*REG_AW +: REG_AW])) : {NBITS{1'b0}});
    end
  end

  // Destination being marked pending by an issuing writer.
  always_comb begin
    set_mask = set ? onehot(int'(set_file), int'(set_addr)) : {NBITS{1'b0}};
  end

  // With bypass the register file is written first, so a bit being
  // cleared this cycle no longer blocks Decode.
  always_comb begin
    visible = (WB_BYPASS != 0) ? (bits & ~clr_mask) : bits;
    rd_a    = |(visible & onehot(int'(rd_a_file), int'(rd_a_addr)));
    rd_b    = |(visible & onehot(int'(rd_b_file), int'(rd_b_addr)));
    rd_d    = |(visible & onehot(int'(rd_d_file), int'(rd_d_addr)));
  end

  // Scoreboard state: clears apply first, then the set, so set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      bits <= {NBITS{1'b0}};
    end else begin
      bits <= (bits & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: rtl/npu_hazard_ctrl.sv
// npu_hazard_ctrl
// Hazard and flush controller for the in-order F/D/E/M/W NPU pipeline.
// Stalls Decode on RAW/WAW against a pending-write scoreboard, turns taken
// branches (Execute) and jumps (Decode) into flush/bubble controls, tracks
// per-stage valid bits and counts stall and flush cycles.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   id_*                       Decode operand/destination descriptors
//   jmp, b_taken               jump in Decode, taken branch in Execute
//   wb_clr, wb_rD              per-file writeback retire strobe and address
//   stall_pc, stall_fd         hold PC / Fetch-to-Decode register
//   flush_fd, bubble_de        NOP into Fetch-to-Decode / Decode-to-Execute
//   issue                      Decode instruction advances this cycle
//   stage_v                    valid bits {W, M, E, D}
//   pending                    scoreboard bits, flat {file, reg}
//   stall_cnt, flush_cnt       saturating event counters
module npu_hazard_ctrl
  import npu_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW    = NPU_REG_AW,
  parameter int NUM_FILES = 2,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              id_valid,
  input  logic                              id_useA,
  input  logic                              id_useB,
  input  logic [file_w(NUM_FILES)-1:0]      id_fileA,
  input  logic [file_w(NUM_FILES)-1:0]      id_fileB,
  input  logic [REG_AW-1:0]                 id_rA,
  input  logic [REG_AW-1:0]                 id_rB,
  input  logic                              id_wr,
  input  logic [file_w(NUM_FILES)-1:0]      id_fileD,
  input  logic [REG_AW-1:0]                 id_rD,
  input  logic                              jmp,
  input  logic                              b_taken,
  input  logic [NUM_FILES-1:0]              wb_clr,
  input  logic [NUM_FILES*REG_AW-1:0]       wb_rD,
  output logic                              stall_pc,
  output logic                              stall_fd,
  output logic                              flush_fd,
  output logic                              bubble_de,
  output logic                              issue,
  output logic [NUM_STAGES-2:0]             stage_v,
  output logic [NUM_FILES*(2**REG_AW)-1:0]  pending,
  output logic [CNT_W-1:0]                  stall_cnt,
  output logic [CNT_W-1:0]                  flush_cnt
);

  localparam int NV = NUM_STAGES - 1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic                             rd_a;
  logic                             rd_b;
  logic                             rd_d;
  logic                             haz;
  logic                             do_issue;
  flush_cause_e                     cause;
  logic [NUM_FILES*(2**REG_AW)-1:0] sb_bits;
  logic [NV-1:0]                    stage_bits;
  logic [CNT_W-1:0]                 stall_count;
  logic [CNT_W-1:0]                 flush_count;

  npu_scoreboard #(
    .REG_AW    (REG_AW),
    .NUM_FILES (NUM_FILES),
    .WB_BYPASS (WB_BYPASS)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .clr       (wb_clr),
    .clr_addr  (wb_rD),
    .set       (do_issue & id_wr),
    .set_file  (id_fileD),
    .set_addr  (id_rD),
    .rd_a_file (id_fileA),
    .rd_a_addr (id_rA),
    .rd_b_file (id_fileB),
    .rd_b_addr (id_rB),
    .rd_d_file (id_fileD),
    .rd_d_addr (id_rD),
    .rd_a      (rd_a),
    .rd_b      (rd_b),
    .rd_d      (rd_d),
    .bits      (sb_bits)
  );

  // RAW on either operand or WAW on the destination.
  always_comb begin
    haz = id_valid & ((id_useA & rd_a) | (id_useB & rd_b) | (id_wr & rd_d));
  end

  // A hazarded jump must not flush Fetch yet: F and D hold until the jump
  // itself issues, so the hazard is ranked above the jump here.
  always_comb begin
    cause = FC_NONE;
    if (reset) begin
      cause = FC_NONE;
    end else if (b_taken) begin
      cause = FC_BRANCH;
    end else if (haz) begin
      cause = FC_HAZ;
    end else if (jmp) begin
      cause = FC_JMP;
    end else begin
      cause = FC_NONE;
    end
  end

  // Pipeline-register controls for each cause.
  always_comb begin
    stall_pc  = 1'b0;
    stall_fd  = 1'b0;
    flush_fd  = 1'b0;
    bubble_de = 1'b0;
    case (cause)
      FC_BRANCH: begin
        flush_fd  = 1'b1;
        bubble_de = 1'b1;
      end
      FC_HAZ: begin
        stall_pc  = 1'b1;
        stall_fd  = 1'b1;
        bubble_de = 1'b1;
      end
      FC_JMP: begin
        flush_fd  = 1'b1;
      end
      default: begin
        stall_pc  = 1'b0;
        stall_fd  = 1'b0;
        flush_fd  = 1'b0;
        bubble_de = 1'b0;
      end
    endcase
  end

  // Decode advances when it holds a hazard-free instruction and no branch squashes it.
  always_comb begin
    do_issue = ~reset & id_valid & ~haz & ~b_taken;
  end

  // Stage valid shift register {W, M, E, D} and saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_bits  <= {NV{1'b0}};
      stall_count <= {CNT_W{1'b0}};
      flush_count <= {CNT_W{1'b0}};
    end else begin
      stage_bits <= {stage_bits[NV-2:1], do_issue, id_valid & ~flush_fd};
      if (stall_pc && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + CNT_ONE;
      end else begin
        stall_count <= stall_count;
      end
      if (flush_fd && (flush_count != CNT_MAX)) begin
        flush_count <= flush_count + CNT_ONE;
      end else begin
        flush_count <= flush_count;
      end
    end
  end

  // All outputs read as zero for as long as reset is held.
  always_comb begin
    issue     = do_issue;
    stage_v   = reset ? {NV{1'b0}} : stage_bits;
    pending   = reset ? {(NUM_FILES*(2**REG_AW)){1'b0}} : sb_bits;
    stall_cnt = reset ? {CNT_W{1'b0}} : stall_count;
    flush_cnt = reset ? {CNT_W{1'b0}} : flush_count;
  end

endmodule

// File: tb/tb_npu_hazard_ctrl.sv
// Testbench for npu_hazard_ctrl (REG_AW=5, two files, WB bypass on, 4-bit
// counters so saturation is reachable). A table of per-cycle vectors carries
// inputs and hand-derived control outputs; a bench model tracks pending bits,
// counters and D/E/M valid bits, and a queue of issue events predicts the W
// valid bit three cycles later.
module tb_npu_hazard_ctrl;
  import npu_hazard_ctrl_pkg::*;

  localparam int AW = 5;
  localparam int NF = 2;
  localparam int CW = 4;
  localparam int NB = NF * 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          id_valid = 1'b0, id_useA = 1'b0, id_useB = 1'b0;
  logic [0:0]    id_fileA = 1'b0, id_fileB = 1'b0, id_fileD = 1'b0;
  logic [AW-1:0] id_rA = '0, id_rB = '0, id_rD = '0;
  logic          id_wr = 1'b0, jmp = 1'b0, b_taken = 1'b0;
  logic [NF-1:0] wb_clr = '0;
  logic [NF*AW-1:0] wb_rD = '0;
  logic          stall_pc, stall_fd, flush_fd, bubble_de, issue;
  logic [3:0]    stage_v;
  logic [NB-1:0] pending;
  logic [CW-1:0] stall_cnt, flush_cnt;

  npu_hazard_ctrl #(.REG_AW(AW), .NUM_FILES(NF), .WB_BYPASS(1), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_useA(id_useA), .id_useB(id_useB),
    .id_fileA(id_fileA), .id_fileB(id_fileB), .id_rA(id_rA), .id_rB(id_rB),
    .id_wr(id_wr), .id_fileD(id_fileD), .id_rD(id_rD), .jmp(jmp), .b_taken(b_taken),
    .wb_clr(wb_clr), .wb_rD(wb_rD), .stall_pc(stall_pc), .stall_fd(stall_fd),
    .flush_fd(flush_fd), .bubble_de(bubble_de), .issue(issue), .stage_v(stage_v),
    .pending(pending), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          valid, ua, ub, wr, jmp, bt;
    logic [0:0]    fa, fb, fd;
    logic [AW-1:0] ra, rb, rd, cr0, cr1;
    logic [1:0]    clr;
    logic          e_stall, e_flush, e_bubble, e_issue;
  } vec_t;

  vec_t          tbl[$];
  int            n_chk = 0;
  int            n_fail = 0;
  logic [NB-1:0] m_pend;
  logic [CW-1:0] m_stall, m_flush;
  logic [3:0]    m_sv;
  bit            w_q[$];

  function automatic vec_t mk(int valid, int ua, int fa, int ra, int ub, int fb, int rb,
                              int wr, int fd, int rd, int jp, int bt, int clr, int cr0, int cr1,
                              int es, int ef, int eb, int ei);
    vec_t v;
    v.valid = 1'(valid); v.ua = 1'(ua); v.fa = 1'(fa); v.ra = 5'(ra);
    v.ub = 1'(ub); v.fb = 1'(fb); v.rb = 5'(rb);
    v.wr = 1'(wr); v.fd = 1'(fd); v.rd = 5'(rd); v.jmp = 1'(jp); v.bt = 1'(bt);
    v.clr = 2'(clr); v.cr0 = 5'(cr0); v.cr1 = 5'(cr1);
    v.e_stall = 1'(es); v.e_flush = 1'(ef); v.e_bubble = 1'(eb); v.e_issue = 1'(ei);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    id_valid = v.valid; id_useA = v.ua; id_fileA = v.fa; id_rA = v.ra;
    id_useB = v.ub; id_fileB = v.fb; id_rB = v.rb;
    id_wr = v.wr; id_fileD = v.fd; id_rD = v.rd; jmp = v.jmp; b_taken = v.bt;
    wb_clr = v.clr; wb_rD = {v.cr1, v.cr0};
  endtask

  task automatic model_reset();
    m_pend = '0; m_stall = '0; m_flush = '0; m_sv = '0;
    w_q.delete();
    for (int i = 0; i < 3; i++) w_q.push_back(1'b0);
  endtask

  // One cycle: drive at posedge+1, check at negedge, advance model, go to next posedge+1.
  task automatic step(input vec_t v);
    bit w_exp;
    apply(v);
    @(negedge clk);
    chk("stall_pc", 64'(stall_pc), 64'(v.e_stall));
    chk("stall_fd", 64'(stall_fd), 64'(v.e_stall));
    chk("flush_fd", 64'(flush_fd), 64'(v.e_flush));
    chk("bubble_de", 64'(bubble_de), 64'(v.e_bubble));
    chk("issue", 64'(issue), 64'(v.e_issue));
    chk("pending", 64'(pending), 64'(m_pend));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
    chk("stage_v_dem", 64'(stage_v[2:0]), 64'(m_sv[2:0]));
    w_exp = w_q.pop_front();
    chk("stage_v_w", 64'(stage_v[3]), 64'(w_exp));
    if (v.clr[0]) m_pend[{1'b0, v.cr0}] = 1'b0;
    if (v.clr[1]) m_pend[{1'b1, v.cr1}] = 1'b0;
    if (v.e_issue && v.wr) m_pend[{v.fd, v.rd}] = 1'b1;
    if (v.e_stall && (m_stall != 4'hF)) m_stall = m_stall + 4'd1;
    if (v.e_flush && (m_flush != 4'hF)) m_flush = m_flush + 4'd1;
    m_sv = {m_sv[2:1], v.e_issue, v.valid & ~v.e_flush};
    w_q.push_back(v.e_issue);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall_pc"}, 64'(stall_pc), 64'd0);
    chk({tag, "_stall_fd"}, 64'(stall_fd), 64'd0);
    chk({tag, "_flush_fd"}, 64'(flush_fd), 64'd0);
    chk({tag, "_bubble_de"}, 64'(bubble_de), 64'd0);
    chk({tag, "_issue"}, 64'(issue), 64'd0);
    chk({tag, "_stage_v"}, 64'(stage_v), 64'd0);
    chk({tag, "_pending"}, 64'(pending), 64'd0);
    chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
    chk({tag, "_flush_cnt"}, 64'(flush_cnt), 64'd0);
  endtask

  initial begin
    //        v ua fa ra ub fb rb wr fd rd jp bt clr c0 c1  st fl bu is
    tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0,  0,0,0,0)); // idle
    tbl.push_back(mk(1,0,0,0, 0,0,0, 1,0,3, 0,0, 0,0,0,  0,0,0,1)); // write r3
    tbl.push_back(mk(1,1,0,3, 0,0,0, 0,0,0, 0,0, 0,0,0,  1,0,1,0)); // RAW r3
    tbl.push_back(mk(1,1,0,3, 0,0,0, 0,0,0, 0,0, 0,0,0,  1,0,1,0)); // still stalled
    tbl.push_back(mk(1,1,0,3, 0,0,0, 0,0,0, 0,0, 1,3,0,  0,0,0,1)); // clear r3: bypass issue
    tbl.push_back(mk(1,0,0,0, 0,0,0, 1,1,7, 0,0, 0,0,0,  0,0,0,1)); // write v7
    tbl.push_back(mk(1,1,0,7, 1,0,7, 1,0,5, 0,0, 0,0,0,  0,0,0,1)); // read r7 (files separate), write r5
    tbl.push_back(mk(1,1,0,5, 0,0,0, 0,0,0, 0,1, 0,0,0,  0,1,1,0)); // b_taken over hazard
    tbl.push_back(mk(1,1,0,1, 0,0,0, 0,0,0, 1,0, 0,0,0,  0,1,0,1)); // clean jump
    tbl.push_back(mk(1,0,0,0, 1,0,5, 0,0,0, 1,0, 0,0,0,  1,0,1,0)); // jump blocked by r5
    tbl.push_back(mk(1,0,0,0, 1,0,5, 0,0,0, 1,0, 1,5,0,  0,1,0,1)); // r5 retires: jump goes
    tbl.push_back(mk(1,0,0,0, 0,0,0, 1,1,7, 0,0, 0,0,0,  1,0,1,0)); // WAW v7
    tbl.push_back(mk(1,0,0,0, 0,0,0, 1,1,7, 0,0, 2,0,7,  0,0,0,1)); // clear+set v7
    tbl.push_back(mk(1,0,0,0, 0,0,0, 1,1,2, 0,0, 0,0,0,  0,0,0,1)); // write v2
    tbl.push_back(mk(1,0,0,0, 0,0,0, 1,1,2, 0,0, 2,0,2,  0,0,0,1)); // clear+set v2
    tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0,0, 0,0, 1,2,0,  0,0,0,0)); // clear unset r2
    tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0,0, 0,1, 0,0,0,  0,1,1,0)); // branch, empty D
    for (int i = 0; i < 13; i++)
      tbl.push_back(mk(1,1,1,2, 0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,1,0)); // long stall: counter saturates
    tbl.push_back(mk(1,1,1,2, 0,0,0, 0,0,0, 0,0, 2,0,2,  0,0,0,1)); // v2 retires
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0)); // drain

    // Reset state: outputs zero while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Reset mid-run with v7 pending and an active hazarded jump in Decode.
    reset = 1'b1;
    apply(mk(1,1,1,7, 0,0,0, 0,0,0, 1,0, 0,0,0, 0,0,0,0));
    @(negedge clk);
    chk_all_zero("midreset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    step(mk(0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0,  0,0,0,0)); // scoreboard dropped
    step(mk(1,0,0,0, 0,0,0, 1,1,7, 0,0, 0,0,0,  0,0,0,1)); // v7 write no longer WAW
    step(mk(1,1,1,7, 0,0,0, 0,0,0, 0,0, 0,0,0,  1,0,1,0)); // RAW on fresh v7
    step(mk(1,1,1,7, 0,0,0, 0,0,0, 0,0, 2,0,7,  0,0,0,1)); // retire
    for (int i = 0; i < 3; i++)
      step(mk(0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
